// File: rtl/pwm_core.sv
// rtl/pwm_core.sv - tick-driven PWM generator with double-buffered duty/period.
// Optional macro PWM_COMPL_EN adds a dead-time separated complementary output on pwm_n.
module pwm_core #(
  parameter int WIDTH      = 8,
  parameter int PERIOD_DEF = 255,
  parameter int DEAD_CYC   = 2
) (
  input  logic             cLocK,
  input  logic             Reset,
  input  logic             NFrec,
  input  logic             run,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_duty,
  input  logic [WIDTH-1:0] wr_period,
  output logic             busy,
  output logic             cyc_done,
  output logic             pwm_out,
  output logic             pwm_n
);

  logic             nfrec_q, nfrec_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] duty_act_q, duty_act_d;
  logic [WIDTH-1:0] period_act_q, period_act_d;
  logic [WIDTH-1:0] pend_duty_q, pend_duty_d;
  logic [WIDTH-1:0] pend_period_q, pend_period_d;
  logic             busy_q, busy_d;
  logic             cyc_done_q, cyc_done_d;
  logic             pwm_out_q, pwm_out_d;
  logic             pwm_n_q, pwm_n_d;
  logic             tick, wrap, pwm_raw;

`ifdef PWM_COMPL_EN
  localparam int DW = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
  logic [DW-1:0] dead_q, dead_d;
  logic          raw_q, raw_d;
`endif

  always_comb begin
    nfrec_d       = NFrec;
    cnt_d         = cnt_q;
    duty_act_d    = duty_act_q;
    period_act_d  = period_act_q;
    pend_duty_d   = pend_duty_q;
    pend_period_d = pend_period_q;
    busy_d        = busy_q;
    cyc_done_d    = 1'b0;
    tick          = NFrec & ~nfrec_q;
    wrap          = run & tick & (cnt_q == period_act_q);
    pwm_raw       = run & (cnt_q < duty_act_q);

    if (run) begin
      if (tick) cnt_d = wrap ? '0 : cnt_q + WIDTH'(1);
      cyc_done_d = wrap;
      // A write landing on the wrap edge bypasses the pending stage entirely
      if (wr_en && wrap) begin
        pend_duty_d   = wr_duty;
        pend_period_d = wr_period;
        duty_act_d    = wr_duty;
        period_act_d  = wr_period;
        busy_d        = 1'b0;
      end else if (wr_en) begin
        pend_duty_d   = wr_duty;
        pend_period_d = wr_period;
        busy_d        = 1'b1;
      end else if (wrap && busy_q) begin
        duty_act_d    = pend_duty_q;
        period_act_d  = pend_period_q;
        busy_d        = 1'b0;
      end
    end else begin
      cnt_d = '0;
      if (wr_en) begin
        pend_duty_d   = wr_duty;
        pend_period_d = wr_period;
        busy_d        = 1'b1;
      end else if (busy_q) begin
        duty_act_d    = pend_duty_q;
        period_act_d  = pend_period_q;
        busy_d        = 1'b0;
      end
    end

`ifdef PWM_COMPL_EN
    // Any edge of pwm_raw reloads the gap; outputs stay low until it drains
    raw_d  = pwm_raw;
    dead_d = dead_q;
    if (pwm_raw != raw_q)  dead_d = DW'(DEAD_CYC);
    else if (dead_q != '0) dead_d = dead_q - DW'(1);
    pwm_out_d = (dead_d == '0) & pwm_raw;
    pwm_n_d   = (dead_d == '0) & run & ~pwm_raw;
`else
    pwm_out_d = pwm_raw;
    pwm_n_d   = 1'b0;
`endif
  end

  always_ff @(posedge cLocK) begin
    if (Reset) begin
      nfrec_q       <= 1'b1;
      cnt_q         <= '0;
      duty_act_q    <= '0;
      period_act_q  <= WIDTH'(PERIOD_DEF);
      pend_duty_q   <= '0;
      pend_period_q <= '0;
      busy_q        <= 1'b0;
      cyc_done_q    <= 1'b0;
      pwm_out_q     <= 1'b0;
      pwm_n_q       <= 1'b0;
`ifdef PWM_COMPL_EN
      dead_q        <= '0;
      raw_q         <= 1'b0;
`endif
    end else begin
      nfrec_q       <= nfrec_d;
      cnt_q         <= cnt_d;
      duty_act_q    <= duty_act_d;
      period_act_q  <= period_act_d;
      pend_duty_q   <= pend_duty_d;
      pend_period_q <= pend_period_d;
      busy_q        <= busy_d;
      cyc_done_q    <= cyc_done_d;
      pwm_out_q     <= pwm_out_d;
      pwm_n_q       <= pwm_n_d;
`ifdef PWM_COMPL_EN
      dead_q        <= dead_d;
      raw_q         <= raw_d;
`endif
    end
  end

  assign busy     = busy_q;
  assign cyc_done = cyc_done_q;
  assign pwm_out  = pwm_out_q;
  assign pwm_n    = pwm_n_q;

endmodule
